// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and FSM encoding for the MMIO console transmitter.
// MMIO_UART_TX_PARITY_EN adds an even-parity bit and a PARITY state.
package mmio_uart_tx_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    localparam logic [ADDR_LEN-1:0] DEF_UART_ADDR   = 32'h0;
    localparam logic [ADDR_LEN-1:0] DEF_FINISH_ADDR = 32'h8;

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Synchronous show-ahead byte FIFO with wrap-bit pointers; push and pop may
// coincide, including a push while full that is paired with a pop.
module tx_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO console transmitter: snoops core stores, queues bytes, sends 8N1 LSB first.
// Define MMIO_UART_TX_PARITY_EN for an even-parity bit after bit7.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int                  CLKS_PER_BIT = 434,
    parameter int                  FIFO_DEPTH   = 16,
    parameter logic [ADDR_LEN-1:0] UART_ADDR    = DEF_UART_ADDR,
    parameter logic [ADDR_LEN-1:0] FINISH_ADDR  = DEF_FINISH_ADDR
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic                we,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic                txd,
    output logic                busy,
    output logic                full,
    output logic                overflow,
    output logic                done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          fin_q, fin_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic       last, pop, push_req, empty, full_w;
    logic [7:0] fifo_dout;
    logic       unused_wdata;

    assign unused_wdata = ^wdata[DATA_LEN-1:8];
    assign last         = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign push_req     = we && (addr == UART_ADDR);

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset_x (reset_x),
        .push    (push_req),
        .din     (wdata[7:0]),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (full_w),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            fin_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            fin_q   <= fin_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The shift register is pre-shifted so sh_q[0] is always the next bit to send.
    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_dout;
                    txd_d   = 1'b0;
                    state_d = ST_START;
`ifdef MMIO_UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            ST_START: if (last) begin
                txd_d   = sh_q[0];
                sh_d    = sh_q >> 1;
                bit_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: if (last) begin
                if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    txd_d   = par_q;
                    state_d = ST_PARITY;
`else
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
`endif
                end else begin
                    txd_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 3'd1;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            ST_PARITY: if (last) begin
                txd_d   = 1'b1;
                state_d = ST_STOP;
            end
`endif
            ST_STOP: if (last) begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_dout;
                    txd_d   = 1'b0;
                    state_d = ST_START;
`ifdef MMIO_UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ovf_d    = ovf_q | (push_req & full_w & ~pop);
        fin_d    = fin_q | (we && (addr == FINISH_ADDR));
        done_d   = fin_q && empty && (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE) || !empty;
        txd      = txd_q;
        full     = full_w;
        overflow = ovf_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset_x = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        txd, busy, full, overflow, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .UART_ADDR    (32'h0),
        .FINISH_ADDR  (32'h8)
    ) dut (
        .clk      (clk),
        .reset_x  (reset_x),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .txd      (txd),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .done     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef MMIO_UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Checks txd for each cycle of one frame starting at frame cycle k0.
    task automatic check_frame(input logic [7:0] b, input int k0);
        for (int k = k0; k < NB*CPB; k++) begin
            chk($sformatf("txd byte=%0h cyc=%0d", b, k), {31'b0, txd}, {31'b0, exp_bit(b, k/CPB)});
            chk($sformatf("busy byte=%0h cyc=%0d", b, k), {31'b0, busy}, 32'd1);
            chk($sformatf("done byte=%0h cyc=%0d", b, k), {31'b0, done}, 32'd0);
            tick();
        end
    endtask

    task automatic check_idle(input string tag, input int n, input logic exp_done);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_txd"}, {31'b0, txd}, 32'd1);
            chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
            chk({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
            tick();
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        reset_x = 1'b1;
        tick();

        // single byte 0x41: idle one cycle after push, then a 10-bit frame
        wr(32'h0, 32'h41);
        chk("t1_txd_after_E", {31'b0, txd}, 32'd1);
        chk("t1_busy_after_E", {31'b0, busy}, 32'd1);
        tick();
        check_frame(8'h41, 0);
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        chk("t1_txd_end", {31'b0, txd}, 32'd1);

        // back-to-back frames, no gap
        wr(32'h0, 32'h55);
        wr(32'h0, 32'hAA);
        check_frame(8'h55, 0);
        check_frame(8'hAA, 0);
        check_idle("t2_idle", 4, 1'b0);

        // six pushes: one popped, four buffered, one dropped
        wr(32'h0, 32'h01);
        wr(32'h0, 32'h80);
        wr(32'h0, 32'h3C);
        wr(32'h0, 32'hC3);
        chk("t3_full_3", {31'b0, full}, 32'd0);
        wr(32'h0, 32'hF0);
        chk("t3_full_4", {31'b0, full}, 32'd1);
        chk("t3_ovf_4", {31'b0, overflow}, 32'd0);
        wr(32'h0, 32'h99);
        chk("t3_full_5", {31'b0, full}, 32'd1);
        chk("t3_ovf_5", {31'b0, overflow}, 32'd1);
        check_frame(8'h01, 4);
        check_frame(8'h80, 0);
        check_frame(8'h3C, 0);
        check_frame(8'hC3, 0);
        check_frame(8'hF0, 0);
        check_idle("t3_idle", 2*NB*CPB, 1'b0);
        chk("t3_ovf_sticky", {31'b0, overflow}, 32'd1);
        chk("t3_full_end", {31'b0, full}, 32'd0);

        // finish request, ignored address
        wr(32'h0, 32'h31);
        wr(32'h8, 32'h0);
        wr(32'h4, 32'h99);
        check_frame(8'h31, 1);
        chk("t4_done_stop_edge", {31'b0, done}, 32'd0);
        tick();
        chk("t4_done_rise", {31'b0, done}, 32'd1);
        check_idle("t4_idle", NB*CPB, 1'b1);

        // reset mid-frame with another byte queued
        wr(32'h0, 32'hFF);
        wr(32'h0, 32'h00);
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("t5_txd cyc=%0d", k), {31'b0, txd}, {31'b0, exp_bit(8'hFF, k/CPB)});
            tick();
        end
        reset_x = 1'b0;
        tick();
        chk("t5_txd", {31'b0, txd}, 32'd1);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_full", {31'b0, full}, 32'd0);
        chk("t5_ovf", {31'b0, overflow}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        reset_x = 1'b1;
        check_idle("t5_idle", 2*NB*CPB, 1'b0);

`ifdef MMIO_UART_TX_PARITY_EN
        wr(32'h0, 32'h07);
        tick();
        check_frame(8'h07, 0);
        wr(32'h0, 32'h03);
        tick();
        check_frame(8'h03, 0);
        check_idle("t6_idle", 4, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
